// File: rtl/mem_ctrl.sv
// Byte-wide unified RAM port controller. Arbitrates between instruction fetch and the MEM stage,
// splits each access into single-byte RAM cycles and rebuilds little-endian words.
module mem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter logic [1:0]  IO_ADDR_TAG = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_read_or_not,
  input  logic [ADDR_W-1:0] if_intru_addr,
  input  logic              if_flush,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [2:0]        mem_len,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [1:0]        mem_ctrl_busy_state,
  output logic              if_load_done,
  output logic [31:0]       mem_ctrl_read_in,
  output logic              mem_load_done,
  output logic [31:0]       mem_rdata
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIfRd  = 3'd1;
  localparam logic [2:0] StMemRd = 3'd2;
  localparam logic [2:0] StMemWr = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              is_if_q, is_if_d;

  logic [ADDR_W-1:0] cur_addr;
  logic              is_rd, is_wr, io_stall;
  logic [7:0]        wr_byte;

  // Unsupported lengths fall back to a full word.
  function automatic logic [2:0] len_bytes(input logic [2:0] l);
    case (l)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cur_addr = addr_q + ADDR_W'(cnt_q);
  assign is_rd    = (state_q == StIfRd) || (state_q == StMemRd);
  assign is_wr    = (state_q == StMemWr);
  assign io_stall = is_wr && (cur_addr[17:16] == IO_ADDR_TAG) && io_buffer_full;

  // Select the store byte for the current byte cycle.
  always_comb begin
    wr_byte = 8'h00;
    case (cnt_q[1:0])
      2'd0: wr_byte = wdata_q[7:0];
      2'd1: wr_byte = wdata_q[15:8];
      2'd2: wr_byte = wdata_q[23:16];
      2'd3: wr_byte = wdata_q[31:24];
      default: wr_byte = 8'h00;
    endcase
  end

  // Next-state: arbitration in idle, byte sequencing, flush abort and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    is_if_d = is_if_q;
    case (state_q)
      StIdle: begin
        if (mem_wr_req || mem_rd_req) begin
          addr_d  = mem_addr;
          len_d   = len_bytes(mem_len);
          wdata_d = mem_wdata;
          is_if_d = 1'b0;
          cnt_d   = 3'd0;
          data_d  = 32'h0;
          state_d = mem_wr_req ? StMemWr : StMemRd;
        end else if (if_read_or_not && !if_flush) begin
          addr_d  = if_intru_addr;
          len_d   = 3'd4;
          is_if_d = 1'b1;
          cnt_d   = 3'd0;
          data_d  = 32'h0;
          state_d = StIfRd;
        end
      end
      StIfRd, StMemRd: begin
        // RAM returns the byte addressed in the previous cycle.
        case (cnt_q)
          3'd1:    data_d[7:0]   = mem_din;
          3'd2:    data_d[15:8]  = mem_din;
          3'd3:    data_d[23:16] = mem_din;
          3'd4:    data_d[31:24] = mem_din;
          default: ;
        endcase
        if (cnt_q == len_q) state_d = StDone;
        else cnt_d = cnt_q + 3'd1;
        if (state_q == StIfRd && if_flush) state_d = StIdle;
      end
      StMemWr: begin
        if (!io_stall) begin
          if (cnt_q == len_q - 3'd1) state_d = StDone;
          else cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; everything holds while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      len_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      is_if_q <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      is_if_q <= is_if_d;
    end
  end

  assign mem_a    = (is_rd || is_wr) ? cur_addr : '0;
  assign mem_dout = is_wr ? wr_byte : 8'h00;
  assign mem_wr   = rdy_in && is_wr && !io_stall;

  assign mem_ctrl_busy_state = {(state_q != StIdle) && !is_if_q, (state_q != StIdle) && is_if_q};

  // Done pulses only on an advancing cycle; a flush in DONE suppresses the IF pulse.
  assign if_load_done  = rdy_in && (state_q == StDone) && is_if_q && !if_flush;
  assign mem_load_done = rdy_in && (state_q == StDone) && !is_if_q;

  assign mem_ctrl_read_in = data_q;
  assign mem_rdata        = data_q;

endmodule
